freq_sweep_sequencer: RTL
=========================

Name: freq_sweep_sequencer

Overview:
- Scheduler that sits between the host-side configuration logic and the frequency-counter measurement core.
- On a start pulse it walks a channel mask in ascending order. For each channel it drives input_select and cycle_count, fires a one-cycle enable, waits for the core's done rising edge or a timeout, and stores edge_count in a per-channel result buffer.
- The host reads results through a registered read port after sweep_done.

Parameters:
DATA_WIDTH, 32, width of counts, select and timeout values
NCHAN, 8, number of selectable counter inputs
CHAN_WIDTH, 3, index width, equal to clog2(NCHAN)

Ports:
clock  in  1  system clock
nreset  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a sweep
abort  in  1  one-cycle request to stop the sweep immediately
chan_mask  in  NCHAN  channels to measure; bit i selects channel i
cycles  in  DATA_WIDTH  gate length in reference cycles per measurement
timeout  in  DATA_WIDTH  maximum clocks to wait for done; 0 disables the timeout
busy  out  1  high while a sweep is in progress
sweep_done  out  1  one-cycle pulse when a sweep completes normally
cycle_count  out  DATA_WIDTH  to counter core
input_select  out  DATA_WIDTH  to counter core; channel index, zero-extended
enable  out  1  to counter core; one-cycle start pulse
done  in  1  from counter core; level signal, high when a measurement is finished
edge_count  in  DATA_WIDTH  from counter core; valid when done is high
res_rd  in  1  result read strobe
res_addr  in  CHAN_WIDTH  result index to read
res_data  out  DATA_WIDTH  result word
res_valid  out  1  high one cycle after res_rd
timeout_flags  out  NCHAN  bit i set if channel i timed out in the last sweep

Behaviour:
- Clock and reset: single clock domain; clock and nreset only. All state is asynchronously cleared when nreset is low.
- Reset values: busy=0, sweep_done=0, enable=0, res_valid=0, cycle_count=0, input_select=0, res_data=0, timeout_flags=0, all result words=0, done_d1=0, FSM in IDLE.
- Latching: chan_mask, cycles and timeout are latched at the start edge. Later input changes have no effect until the next sweep.
- Edge detection: done_d1 is registered every cycle. A capture requires done=1 and done_d1=0; a done level left high from an earlier measurement is ignored.

FSM states: IDLE, SELECT, ARM, WAIT.
- IDLE:
  - start with a non-zero mask: ch = lowest set bit; input_select = ch; cycle_count = latched cycles; busy = 1; clear timeout_flags bits for masked channels; go to SELECT.
  - start with mask = 0: sweep_done pulses on the next cycle; busy stays 0; state stays IDLE.
- SELECT: one settle cycle for the selected input; go to ARM.
- ARM: enable = 1 for exactly this one cycle; clear the wait counter; go to WAIT.
- WAIT: the wait counter increments every cycle.
  - done rising edge: result[ch] = edge_count.
  - timeout != 0 and wait counter == timeout-1 with no done edge: result[ch] = 0 and timeout_flags[ch] = 1.
  - After either outcome: go to the next higher masked channel, with input_select updated at the same edge, and enter SELECT. If no masked channel remains: go to IDLE, busy = 0, and pulse sweep_done for 1 cycle.
- Latency: start at edge T0 gives enable high in the cycle after edge T1. The result write and the next input_select update share one edge.
- start while busy: ignored.
- abort: any non-IDLE state returns to IDLE at the next edge. enable is forced to 0, busy = 0, no sweep_done pulse. Completed results are kept; unmeasured channels keep their old values.
- Priority on the same edge: abort over done edge over timeout.
- Result read: res_rd latches result[res_addr] into res_data at the next edge, and res_valid goes high for that one cycle. Reads are legal while busy. A read and a write to the same index on the same edge return the old value.
- Channel order: ascending index; each masked channel is visited exactly once per sweep.

Test Plan:
- Reset, then sweep mask=8'b0000_0101, cycles=1000, timeout=0; core model returns done 50 clocks after enable with edge_count=1234 (ch0) and 5678 (ch2) -> input_select goes 0 then 2, two single-cycle enable pulses, sweep_done once, res_data reads 1234 / 0 / 5678 for indices 0 / 1 / 2, and cycle_count=1000.
- Mask=8'b1000_0000, timeout=20, core never raises done -> at exactly 20 clocks in WAIT, result[7]=0, timeout_flags=8'h80, sweep_done pulses.
- done held high from the previous measurement when the next channel is armed -> no capture until done falls and rises again; the stored value is the new edge_count.
- abort during WAIT of channel 1 in a mask=8'h07 sweep -> IDLE next edge, busy=0, no sweep_done, result[0] updated, result[1] and result[2] unchanged; start again while busy was high is ignored.
- start with mask=0 -> sweep_done pulses the next cycle, enable never asserts, busy stays 0. nreset pulsed mid-WAIT -> all outputs and results return to 0 immediately.

Source files
------------

// File: rtl/freq_sweep_sequencer.sv
// freq_sweep_sequencer
//
// Runs one frequency measurement for each channel selected in a mask, in
// ascending channel order. Each result goes into a per-channel buffer that
// the host reads back.
//
// Ports:
//   clock, nreset         system clock, asynchronous active-low reset
//   start, abort          one-cycle sweep start / stop requests
//   chan_mask             channels to measure (latched at start)
//   cycles, timeout       gate length and done timeout (latched at start;
//                         timeout 0 disables the timeout)
//   busy, sweep_done      sweep in progress / one-cycle normal completion
//   cycle_count           gate length driven to the counter core
//   input_select          channel index driven to the counter core
//   enable                one-cycle start pulse to the counter core
//   done, edge_count      completion level and result from the counter core
//   res_rd, res_addr      result read strobe and index
//   res_data, res_valid   registered read data, valid one cycle after res_rd
//   timeout_flags         bit i set if channel i timed out in its last sweep
//   state_dbg             current FSM state (IDLE=0, SELECT=1, ARM=2, WAIT=3)
//
// Core handshake: enable is a single-cycle request with no ready signal.
// Completion is the rising edge of the done level: done=1 this cycle and
// done=0 in the previous cycle. A done level still high from an earlier
// measurement is never taken as completion. edge_count is sampled on that
// same edge.

module freq_sweep_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int NCHAN      = 8,
  parameter int CHAN_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NCHAN-1:0]      chan_mask,
  input  logic [DATA_WIDTH-1:0] cycles,
  input  logic [DATA_WIDTH-1:0] timeout,
  output logic                  busy,
  output logic                  sweep_done,
  output logic [DATA_WIDTH-1:0] cycle_count,
  output logic [DATA_WIDTH-1:0] input_select,
  output logic                  enable,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] edge_count,
  input  logic                  res_rd,
  input  logic [CHAN_WIDTH-1:0] res_addr,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_valid,
  output logic [NCHAN-1:0]      timeout_flags,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_ARM    = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [NCHAN-1:0]        mask_q;
  logic [DATA_WIDTH-1:0]   timeout_q;
  logic [DATA_WIDTH-1:0]   wait_cnt;
  logic [CHAN_WIDTH-1:0]   ch;
  logic                    done_d1;
  logic [DATA_WIDTH-1:0]   result_mem [NCHAN];

  logic                    done_rise;
  logic                    timeout_hit;
  logic                    meas_end;
  logic                    abort_now;
  logic                    first_found;
  logic [CHAN_WIDTH-1:0]   first_ch;
  logic                    next_found;
  logic [CHAN_WIDTH-1:0]   next_ch;

  assign state_dbg   = state;
  assign done_rise   = done & ~done_d1;
  assign timeout_hit = (timeout_q != '0) && (wait_cnt == timeout_q - DATA_WIDTH'(1));
  assign abort_now   = abort && (state != S_IDLE);
  // Abort beats a done edge, which beats the timeout.
  assign meas_end    = (state == S_WAIT) && !abort_now && (done_rise || timeout_hit);

  // Lowest set bit of the incoming mask: the first channel of a new sweep.
  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (chan_mask[i]) begin
        first_found = 1'b1;
        first_ch    = CHAN_WIDTH'(i);
      end
    end
  end

  // Lowest latched-mask bit strictly above the current channel.
  always_comb begin
    next_found = 1'b0;
    next_ch    = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(ch))) begin
        next_found = 1'b1;
        next_ch    = CHAN_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start && first_found) state_nxt = S_SELECT;
      S_SELECT: state_nxt = S_ARM;
      S_ARM:    state_nxt = S_WAIT;
      S_WAIT:   if (meas_end) state_nxt = next_found ? S_SELECT : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort_now) state_nxt = S_IDLE;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      busy          <= 1'b0;
      sweep_done    <= 1'b0;
      enable        <= 1'b0;
      cycle_count   <= '0;
      input_select  <= '0;
      res_data      <= '0;
      res_valid     <= 1'b0;
      timeout_flags <= '0;
      done_d1       <= 1'b0;
      mask_q        <= '0;
      timeout_q     <= '0;
      wait_cnt      <= '0;
      ch            <= '0;
      for (int i = 0; i < NCHAN; i++) result_mem[i] <= '0;
    end else begin
      done_d1    <= done;
      sweep_done <= 1'b0;
      // enable is registered so it is high exactly during the ARM cycle.
      enable     <= (state == S_SELECT) && !abort;
      res_valid  <= res_rd;
      // Non-blocking read: a same-edge write to this index returns old data.
      if (res_rd) res_data <= result_mem[res_addr];

      case (state)
        S_IDLE: begin
          if (start) begin
            if (first_found) begin
              mask_q        <= chan_mask;
              cycle_count   <= cycles;
              timeout_q     <= timeout;
              ch            <= first_ch;
              input_select  <= DATA_WIDTH'(first_ch);
              busy          <= 1'b1;
              timeout_flags <= timeout_flags & ~chan_mask;
            end else begin
              sweep_done <= 1'b1;
            end
          end
        end
        S_ARM:  wait_cnt <= '0;
        S_WAIT: wait_cnt <= wait_cnt + DATA_WIDTH'(1);
        default: ;
      endcase

      if (meas_end) begin
        if (done_rise) begin
          result_mem[ch] <= edge_count;
        end else begin
          result_mem[ch]    <= '0;
          timeout_flags[ch] <= 1'b1;
        end
        if (next_found) begin
          ch           <= next_ch;
          input_select <= DATA_WIDTH'(next_ch);
        end else begin
          busy       <= 1'b0;
          sweep_done <= 1'b1;
        end
      end

      if (abort_now) busy <= 1'b0;
    end
  end

endmodule
